// File: rtl/upper_layer_merge_unit.sv
// -----------------------------------------------------------------------------
// upper_layer_merge_unit
//
// Consumer end of the lower-layer sorted-stream interface. Two lower-layer
// sorters (A and B) each deliver one ascending run of up to BLOCK elements,
// one element per update strobe, with no backpressure. Both runs are captured
// into local buffers and then merged into a single ascending run of up to
// 2*BLOCK elements. That run is re-emitted on the same serial update/done
// protocol, so several layers can be cascaded.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_a       run A element, valid while update_a=1
//   update_a     run A element strobe
//   done_a       run A complete (may coincide with the last update_a)
//   data_b       run B element, valid while update_b=1
//   update_b     run B element strobe
//   done_b       run B complete (may coincide with the last update_b)
//   sorted_data  merged element, registered; holds its value when update=0
//   update       one-cycle strobe: sorted_data is valid
//   done         one-cycle pulse on the last merged element (alone if empty)
//   busy         collecting or merging
//   err          sticky protocol error (overflow or traffic during merge)
// -----------------------------------------------------------------------------
module upper_layer_merge_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  update_a,
  input  logic                  done_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  update_b,
  input  logic                  done_b,
  output logic [DATA_WIDTH-1:0] sorted_data,
  output logic                  update,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  // Counter width is derived from BLOCK and must not be overridden.
  localparam int CW = $clog2(BLOCK) + 1;
  localparam int AW = CW - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_MERGE,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] buf_a [BLOCK];
  logic [DATA_WIDTH-1:0] buf_b [BLOCK];
  logic [CW-1:0]         cnt_a, cnt_b;
  logic [CW-1:0]         rd_a, rd_b;
  logic                  cmp_a, cmp_b;

  // In DONE the counters and flags are being cleared, so a run that starts
  // in that cycle must see them as already zero.
  logic [CW-1:0] base_a, base_b;
  logic          base_cmp_a, base_cmp_b;
  logic          any_event;

  // Merge datapath.
  logic                  have_a, have_b;
  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic                  take_a, take_b;
  logic [CW:0]           total, emitted_next;
  logic                  last;

  assign any_event  = update_a | done_a | update_b | done_b;
  assign base_a     = (state == S_DONE) ? '0 : cnt_a;
  assign base_b     = (state == S_DONE) ? '0 : cnt_b;
  assign base_cmp_a = (state == S_DONE) ? 1'b0 : cmp_a;
  assign base_cmp_b = (state == S_DONE) ? 1'b0 : cmp_b;

  assign have_a = rd_a < cnt_a;
  assign have_b = rd_b < cnt_b;
  // The index is only used while the side still has data, so rd_x < BLOCK.
  assign head_a = buf_a[rd_a[AW-1:0]];
  assign head_b = buf_b[rd_b[AW-1:0]];
  // Ties favour A so equal keys keep the A-before-B order.
  assign take_a = have_a && (!have_b || (head_a <= head_b));
  assign take_b = have_b && !take_a;

  assign total        = {1'b0, cnt_a} + {1'b0, cnt_b};
  assign emitted_next = {1'b0, rd_a} + {1'b0, rd_b} + (CW+1)'(1);
  assign last         = (total == '0) || (emitted_next == total);

  assign busy = (state == S_COLLECT) || (state == S_MERGE);

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: state_d = any_event ? S_COLLECT : S_IDLE;
      S_COLLECT: begin
        if ((cmp_a | done_a) && (cmp_b | done_b)) state_d = S_MERGE;
      end
      S_MERGE: begin
        if (last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the capture buffers are cleared by reset as well, so a
      // restarted block never exposes elements from an aborted run.
      for (int i = 0; i < BLOCK; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
      cnt_a       <= '0;
      cnt_b       <= '0;
      rd_a        <= '0;
      rd_b        <= '0;
      cmp_a       <= 1'b0;
      cmp_b       <= 1'b0;
      sorted_data <= '0;
      update      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      update <= 1'b0;
      done   <= 1'b0;

      if (state == S_MERGE) begin
        // The lower layers must be quiet while we merge.
        if (any_event) err <= 1'b1;

        if (take_a) begin
          sorted_data <= head_a;
          rd_a        <= rd_a + CW'(1);
          update      <= 1'b1;
        end else if (take_b) begin
          sorted_data <= head_b;
          rd_b        <= rd_b + CW'(1);
          update      <= 1'b1;
        end

        if (last) done <= 1'b1;
      end else begin
        // IDLE, COLLECT and DONE all accept input; DONE also clears the
        // previous run, and the capture below overrides that clear.
        if (state == S_DONE) begin
          cnt_a <= '0;
          cnt_b <= '0;
          rd_a  <= '0;
          rd_b  <= '0;
        end
        cmp_a <= base_cmp_a | done_a;
        cmp_b <= base_cmp_b | done_b;

        if (update_a) begin
          if (base_a < CW'(BLOCK)) begin
            buf_a[base_a[AW-1:0]] <= data_a;
            cnt_a                 <= base_a + CW'(1);
          end else begin
            err <= 1'b1;
          end
        end

        if (update_b) begin
          if (base_b < CW'(BLOCK)) begin
            buf_b[base_b[AW-1:0]] <= data_b;
            cnt_b                 <= base_b + CW'(1);
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_upper_layer_merge_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for upper_layer_merge_unit.
// Every run driven pushes its expected merged elements and its length into
// scoreboard queues; a negedge monitor pops and compares as the DUT emits.
// -----------------------------------------------------------------------------
module tb_upper_layer_merge_unit;

  typedef logic [7:0] elem_t;

  logic  clk;
  logic  rst_n;
  elem_t data_a, data_b;
  logic  update_a, done_a, update_b, done_b;
  elem_t sorted_data;
  logic  update, done, busy, err;

  int vectors;
  int miscompares;

  int    cyc_cnt;
  int    done_cyc;
  int    first_upd_cyc;
  int    done_cnt;
  int    run_upd;
  elem_t exp_q[$];
  int    len_q[$];

  upper_layer_merge_unit #(
    .DATA_WIDTH (8),
    .BLOCK      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_a      (data_a),
    .update_a    (update_a),
    .done_a      (done_a),
    .data_b      (data_b),
    .update_b    (update_b),
    .done_b      (done_b),
    .sorted_data (sorted_data),
    .update      (update),
    .done        (done),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard monitor: compares each emitted element and each run length.
  always @(negedge clk) begin
    if (rst_n) begin
      if (update) begin
        vectors++;
        run_upd++;
        if (first_upd_cyc < 0) first_upd_cyc = cyc_cnt;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_update got=%0d expected=none", sorted_data);
        end else begin
          elem_t e;
          e = exp_q.pop_front();
          if (sorted_data !== e) begin
            miscompares++;
            $display("FAIL merged_element got=%0d expected=%0d", sorted_data, e);
          end
        end
      end
      if (done) begin
        vectors++;
        done_cnt++;
        if (len_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done got=1 expected=0");
        end else begin
          int l;
          l = len_q.pop_front();
          if (run_upd !== l) begin
            miscompares++;
            $display("FAIL run_length got=%0d expected=%0d", run_upd, l);
          end
        end
        run_upd = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    data_a = '0; update_a = 0; done_a = 0;
    data_b = '0; update_b = 0; done_b = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Drives one run pair; B is held off for b_delay cycles. With rnd set the
  // element spacing and the done timing are randomised. Expected output is
  // the sorted multiset of the first 4 elements of each side.
  task automatic drive_runs(input elem_t a[$], input elem_t b[$],
                            input int b_delay, input bit rnd);
    int    ia = 0;
    int    ib = 0;
    bit    da = 0;
    bit    db = 0;
    int    cyc = 0;
    elem_t m[$];
    for (int i = 0; i < a.size() && i < 4; i++) m.push_back(a[i]);
    for (int i = 0; i < b.size() && i < 4; i++) m.push_back(b[i]);
    m.sort();
    foreach (m[i]) exp_q.push_back(m[i]);
    len_q.push_back(m.size());
    while (!(da && db)) begin
      @(posedge clk); #1;
      clear_inputs();
      if (!da && (!rnd || $urandom_range(0, 1) == 1)) begin
        if (ia < a.size()) begin data_a = a[ia]; update_a = 1; ia++; end
        if (ia == a.size() && (!rnd || $urandom_range(0, 1) == 1)) begin
          done_a = 1; da = 1; done_cyc = cyc_cnt;
        end
      end
      if (!db && cyc >= b_delay && (!rnd || $urandom_range(0, 1) == 1)) begin
        if (ib < b.size()) begin data_b = b[ib]; update_b = 1; ib++; end
        if (ib == b.size() && (!rnd || $urandom_range(0, 1) == 1)) begin
          done_b = 1; db = 1; done_cyc = cyc_cnt;
        end
      end
      cyc++;
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic wait_runs(output bit timed_out);
    int n = 0;
    timed_out = 0;
    while (len_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin timed_out = 1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    apply_reset();
    #1;
    vectors++;
    if ({update, done, busy, err, sorted_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%0d expected=0/0/0/0/0",
               update, done, busy, err, sorted_data);
    end
  endtask

  task automatic test_basic();
    elem_t a[$] = '{8'd3, 8'd10, 8'd20, 8'd200};
    elem_t b[$] = '{8'd1, 8'd15, 8'd16, 8'd255};
    bit to;
    int d0;
    first_upd_cyc = -1;
    d0 = done_cnt;
    drive_runs(a, b, 0, 0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy got=%b expected=1", busy);
    end
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL basic_timeout got=1 expected=0"); end
    vectors++;
    if (first_upd_cyc - done_cyc !== 2) begin
      miscompares++;
      $display("FAIL basic_latency got=%0d expected=2", first_upd_cyc - done_cyc);
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_done_count got=%0d expected=1", done_cnt - d0);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, err} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_idle_flags got=%b expected=00", {busy, err});
    end
  endtask

  task automatic test_ties_skew();
    elem_t a[$] = '{8'd5, 8'd5, 8'd7, 8'd9};
    elem_t b[$] = '{8'd5, 8'd7, 8'd8, 8'd9};
    bit to;
    first_upd_cyc = -1;
    drive_runs(a, b, 6, 0);
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL ties_timeout got=1 expected=0"); end
    vectors++;
    if (first_upd_cyc - done_cyc !== 2) begin
      miscompares++;
      $display("FAIL ties_start_after_done_b got=%0d expected=2", first_upd_cyc - done_cyc);
    end
  endtask

  task automatic test_short_empty();
    elem_t a[$] = '{8'd4, 8'd8};
    elem_t e[$];
    bit to;
    int d0;
    drive_runs(a, e, 0, 0);
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL short_timeout got=1 expected=0"); end
    d0 = done_cnt;
    first_upd_cyc = -1;
    drive_runs(e, e, 0, 0);
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL empty_timeout got=1 expected=0"); end
    vectors++;
    if (done_cnt - d0 !== 1 || first_upd_cyc !== -1) begin
      miscompares++;
      $display("FAIL empty_run got=%0d dones/%0d first_upd expected=1/-1",
               done_cnt - d0, first_upd_cyc);
    end
  endtask

  task automatic test_back_to_back();
    elem_t a1[$] = '{8'd2, 8'd40};
    elem_t b1[$] = '{8'd30};
    elem_t a2[$] = '{8'd9, 8'd90, 8'd91};
    elem_t b2[$] = '{8'd0, 8'd100};
    bit to;
    int d0;
    d0 = done_cnt;
    drive_runs(a1, b1, 0, 0);
    // Three elements to merge: the DONE cycle is three cycles on.
    repeat (2) @(posedge clk);
    drive_runs(a2, b2, 0, 0);
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL b2b_timeout got=1 expected=0"); end
    vectors++;
    if (done_cnt - d0 !== 2) begin
      miscompares++;
      $display("FAIL b2b_done_count got=%0d expected=2", done_cnt - d0);
    end
  endtask

  task automatic test_random();
    bit to;
    int d0;
    d0 = done_cnt;
    for (int r = 0; r < 500; r++) begin
      elem_t a[$];
      elem_t b[$];
      int la = $urandom_range(0, 4);
      int lb = $urandom_range(0, 4);
      for (int i = 0; i < la; i++) a.push_back(elem_t'($urandom_range(0, 255)));
      for (int i = 0; i < lb; i++) b.push_back(elem_t'($urandom_range(0, 255)));
      a.sort();
      b.sort();
      drive_runs(a, b, $urandom_range(0, 3), 1);
      wait_runs(to);
      if (to) begin
        vectors++;
        miscompares++;
        $display("FAIL random_timeout run=%0d got=1 expected=0", r);
        break;
      end
    end
    vectors++;
    if (done_cnt - d0 !== 500) begin
      miscompares++;
      $display("FAIL random_done_count got=%0d expected=500", done_cnt - d0);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL random_leftover got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    elem_t a[$] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    elem_t b[$] = '{8'd6};
    bit to;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_pre_err got=%b expected=0", err);
    end
    drive_runs(a, b, 0, 0);
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL overflow_timeout got=1 expected=0"); end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_err got=%b expected=1", err);
    end
  endtask

  task automatic test_merge_traffic();
    elem_t a[$] = '{8'd10, 8'd20, 8'd30, 8'd40};
    elem_t b[$] = '{8'd15, 8'd25, 8'd35, 8'd45};
    bit to;
    apply_reset();
    drive_runs(a, b, 0, 0);
    // Now in the first merge cycle: inject an element that must be dropped.
    data_b   = 8'd1;
    update_b = 1;
    @(posedge clk); #1;
    clear_inputs();
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL traffic_timeout got=1 expected=0"); end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL traffic_err got=%b expected=1", err);
    end
  endtask

  task automatic test_reset_mid_merge();
    elem_t a[$] = '{8'd11, 8'd22, 8'd33, 8'd44};
    elem_t b[$] = '{8'd12, 8'd23, 8'd34, 8'd45};
    bit to;
    int d0;
    drive_runs(a, b, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    vectors++;
    if ({update, done, busy, err, sorted_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs got=%b/%b/%b/%b/%0d expected=0/0/0/0/0",
               update, done, busy, err, sorted_data);
    end
    exp_q.delete();
    len_q.delete();
    run_upd = 0;
    d0 = done_cnt;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (20) @(negedge clk);
    vectors++;
    if (done_cnt !== d0) begin
      miscompares++;
      $display("FAIL midreset_no_done got=%0d expected=%0d", done_cnt, d0);
    end
    drive_runs(b, a, 0, 0);
    wait_runs(to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL post_reset_timeout got=1 expected=0"); end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_err got=%b expected=0", err);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc_cnt       = 0;
    done_cyc      = 0;
    first_upd_cyc = -1;
    done_cnt      = 0;
    run_upd       = 0;
    rst_n         = 0;
    clear_inputs();

    test_reset();
    test_basic();
    test_ties_skew();
    test_short_empty();
    test_back_to_back();
    test_random();
    test_overflow();
    test_merge_traffic();
    test_reset_mid_merge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
